// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - age-ordered reservation station with four-bus operand snooping
module reservation_station #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic [22:0]   forwardA,
    input  logic [22:0]   forwardB,
    input  logic [22:0]   forwardC,
    input  logic [22:0]   forwardD,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [55:0]   in_op,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [55:0]   out_op,
    output logic [CW-1:0] count
);
    localparam int IW = $clog2(DEPTH);

    logic [55:0]   entry_q [DEPTH];
    logic [55:0]   entry_d [DEPTH];
    logic [55:0]   shifted [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [CW-1:0] cnt_rem;
    logic [DEPTH-1:0] ready;
    logic [IW-1:0] sel;
    logic          found;
    logic          issue;
    logic          accept;

    // Returns {wait, value}; bus A has the highest priority on a shared tag.
    function automatic logic [16:0] resolve(
        input logic        wait_in,
        input logic [5:0]  tag,
        input logic [15:0] val,
        input logic [22:0] b0,
        input logic [22:0] b1,
        input logic [22:0] b2,
        input logic [22:0] b3
    );
        logic [16:0] r;
        r = {wait_in, val};
        if (wait_in) begin
            if (b0[22] && b0[21:16] == tag)      r = {1'b0, b0[15:0]};
            else if (b1[22] && b1[21:16] == tag) r = {1'b0, b1[15:0]};
            else if (b2[22] && b2[21:16] == tag) r = {1'b0, b2[15:0]};
            else if (b3[22] && b3[21:16] == tag) r = {1'b0, b3[15:0]};
        end
        return r;
    endfunction

    function automatic logic [55:0] snoop(
        input logic [55:0] op,
        input logic [22:0] b0,
        input logic [22:0] b1,
        input logic [22:0] b2,
        input logic [22:0] b3
    );
        logic [16:0] ra;
        logic [16:0] rb;
        ra = resolve(op[1], op[45:40], op[33:18], b0, b1, b2, b3);
        rb = resolve(op[0], op[39:34], op[17:2], b0, b1, b2, b3);
        return {op[55:34], ra[15:0], rb[15:0], ra[16], rb[16]};
    endfunction

    // Source of each slot when the entry below it is issued; the top slot has no source above.
    for (genvar g = 0; g < DEPTH; g++) begin : g_shift
        if (g < DEPTH - 1) begin : g_mid
            assign shifted[g] = entry_q[g+1];
        end else begin : g_top
            assign shifted[g] = entry_q[g];
        end
    end

    always_comb begin
        ready = '0;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ready[i] = (CW'(i) < count_q) && !entry_q[i][1] && !entry_q[i][0];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (!found && ready[i]) begin
                sel   = IW'(i);
                found = 1'b1;
            end
        end
    end

    assign out_valid = found;
    assign out_op    = found ? entry_q[sel] : '0;
    assign in_ready  = (count_q < CW'(DEPTH));
    assign count     = count_q;
    assign issue     = out_valid && out_ready;
    assign accept    = in_valid && in_ready;
    assign cnt_rem   = count_q - CW'(issue);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (issue && IW'(i) >= sel) begin
                entry_d[i] = snoop(shifted[i], forwardA, forwardB, forwardC, forwardD);
            end else begin
                entry_d[i] = snoop(entry_q[i], forwardA, forwardB, forwardC, forwardD);
            end
            if (accept && CW'(i) == cnt_rem) begin
                entry_d[i] = snoop(in_op, forwardA, forwardB, forwardC, forwardD);
            end
        end
        count_d = cnt_rem + CW'(accept);
        // Slot contents beyond count are don't-care, so flush only needs to clear the count.
        if (flush) begin
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - randomized scoreboard bench for reservation_station
module tb_reservation_station;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, out_ready;
    logic [22:0]   fa, fb, fc, fd;
    logic [55:0]   in_op;
    logic          in_ready, out_valid;
    logic [55:0]   out_op;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    reservation_station #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .forwardA(fa), .forwardB(fb), .forwardC(fc), .forwardD(fd),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
        .count(count)
    );

    logic [55:0] mq[$];
    logic [55:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [55:0] mk(input logic [3:0] op, input logic [5:0] rob,
                                       input logic [5:0] la, input logic [5:0] lb,
                                       input logic [15:0] va, input logic [15:0] vb,
                                       input logic wa, input logic wb);
        return {op, rob, la, lb, va, vb, wa, wb};
    endfunction

    function automatic logic [22:0] fw(input logic [5:0] tag, input logic [15:0] val);
        return {1'b1, tag, val};
    endfunction

    // Reference operand capture: the first matching bus in order A,B,C,D supplies the value.
    function automatic logic [55:0] model_snoop(input logic [55:0] op);
        logic [22:0] bus [4];
        logic [55:0] r;
        logic ga, gb;
        bus = '{fa, fb, fc, fd};
        r = op;
        ga = 1'b0;
        gb = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (r[1] && !ga && bus[b][22] && bus[b][21:16] == op[45:40]) begin
                r[33:18] = bus[b][15:0];
                ga = 1'b1;
            end
            if (r[0] && !gb && bus[b][22] && bus[b][21:16] == op[39:34]) begin
                r[17:2] = bus[b][15:0];
                gb = 1'b1;
            end
        end
        if (ga) r[1] = 1'b0;
        if (gb) r[0] = 1'b0;
        return r;
    endfunction

    task automatic idle();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        fa = '0; fb = '0; fc = '0; fd = '0; in_op = '0;
    endtask

    // Inputs are already driven; predict outputs, advance the model, wait for the next negedge.
    task automatic tick();
        int idx;
        int n_before;
        #1;
        idx = -1;
        foreach (mq[i]) if (idx < 0 && !mq[i][1] && !mq[i][0]) idx = i;
        if (!reset) begin
            chk("count", 64'(count), 64'(mq.size()));
            chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
            chk("out_valid", 64'(out_valid), 64'(idx >= 0));
            if (idx >= 0) chk("out_op", 64'(out_op), 64'(mq[idx]));
        end
        if (reset || flush) begin
            mq.delete();
        end else begin
            n_before = mq.size();
            if (out_ready && idx >= 0) begin
                exp_q.push_back(mq[idx]);
                mq.delete(idx);
            end
            foreach (mq[i]) mq[i] = model_snoop(mq[i]);
            if (in_valid && n_before < DEPTH) mq.push_back(model_snoop(in_op));
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        #2;
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_issue", 64'(out_op), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                chk("issued_op", 64'(out_op), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_out_op", 64'(out_op), 64'h0);
        chk("reset_count", 64'(count), 64'h0);

        // Ready-on-dispatch op issues the next cycle.
        in_valid = 1'b1; out_ready = 1'b1;
        in_op = mk(4'h3, 6'd5, 6'd0, 6'd0, 16'h0011, 16'h0022, 1'b0, 1'b0);
        tick();
        idle(); out_ready = 1'b1;
        repeat (2) tick();

        // Wait on tag 7, resolved on bus C after 3 cycles.
        in_valid = 1'b1; in_op = mk(4'h1, 6'd6, 6'd7, 6'd0, 16'h0, 16'h0505, 1'b1, 1'b0);
        tick();
        idle(); out_ready = 1'b1;
        repeat (3) tick();
        fc = fw(6'd7, 16'hBEEF);
        tick();
        idle(); out_ready = 1'b1;
        repeat (2) tick();

        // Fill with waiting entries, release only entry 2, then the rest.
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_op = mk(4'(k), 6'(k + 1), 6'(10 + k), 6'd0, 16'h0, 16'(k), 1'b1, 1'b0);
            tick();
        end
        idle(); out_ready = 1'b1;
        in_valid = 1'b1; in_op = mk(4'hF, 6'd40, 6'd0, 6'd0, 16'h1, 16'h2, 1'b0, 1'b0);
        tick();
        idle(); out_ready = 1'b1; fa = fw(6'd12, 16'hC0DE);
        tick();
        idle(); out_ready = 1'b1;
        repeat (2) tick();
        fa = fw(6'd10, 16'hAAAA); fb = fw(6'd11, 16'hBBBB); fc = fw(6'd13, 16'hDDDD);
        tick();
        idle(); out_ready = 1'b1;
        repeat (4) tick();

        // Entries 1 and 3 ready together under backpressure.
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_op = mk(4'(k + 4), 6'(k + 20), 6'd0, 6'(20 + k), 16'(k), 16'h0, 1'b0, 1'b1);
            tick();
        end
        idle(); fa = fw(6'd21, 16'h2121); fb = fw(6'd23, 16'h2323);
        tick();
        idle();
        repeat (2) tick();
        out_ready = 1'b1;
        repeat (2) tick();
        fa = fw(6'd20, 16'h2020); fb = fw(6'd22, 16'h2222);
        tick();
        idle(); out_ready = 1'b1;
        repeat (3) tick();

        // Dispatch-cycle capture with bus A winning over bus D.
        in_valid = 1'b1; in_op = mk(4'h9, 6'd9, 6'd0, 6'd9, 16'h7777, 16'h0, 1'b0, 1'b1);
        fa = fw(6'd9, 16'h1234); fd = fw(6'd9, 16'h5678);
        tick();
        idle(); out_ready = 1'b1;
        repeat (2) tick();

        // Flush wins over a simultaneous dispatch.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_op = mk(4'h2, 6'(30 + k), 6'(30 + k), 6'd0, 16'h0, 16'h0, 1'b1, 1'b0);
            tick();
        end
        idle(); flush = 1'b1; in_valid = 1'b1;
        in_op = mk(4'h5, 6'd50, 6'd0, 6'd0, 16'h5, 16'h5, 1'b0, 1'b0);
        tick();
        idle();
        tick();

        for (int c = 0; c < 3000; c++) begin
            idle();
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 99) < 3);
            if (flush) out_ready = 1'b0;
            in_op = mk(4'($urandom), 6'($urandom), 6'($urandom_range(0, 7)), 6'($urandom_range(0, 7)),
                       16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            fa = {1'($urandom), 6'($urandom_range(0, 7)), 16'($urandom)};
            fb = {1'($urandom), 6'($urandom_range(0, 7)), 16'($urandom)};
            fc = {1'($urandom), 6'($urandom_range(0, 7)), 16'($urandom)};
            fd = {1'($urandom), 6'($urandom_range(0, 7)), 16'($urandom)};
            tick();
        end

        for (int c = 0; c < 64; c++) begin
            idle(); out_ready = 1'b1;
            fa = fw(6'(c % 8), 16'(c));
            tick();
        end
        chk("drained_count", 64'(count), 64'h0);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
